// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter that owns the write enable of one shared WIDTH-bit
// register; grants one requester per transfer and pulses its Ack on the write.
module rr_reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 8,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ*WIDTH-1:0]   Data_In,
    output logic [NREQ-1:0]         Grant,
    output logic [NREQ-1:0]         Ack,
    output logic [WIDTH-1:0]        Data_Out,
    output logic [IDX_W-1:0]        Owner,
    output logic                    Busy,
    output logic [CNT_W-1:0]        Wr_Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    state_t             r_state;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_ack;
    logic [WIDTH-1:0]   r_data_out;
    logic [IDX_W-1:0]   r_owner;
    logic               r_busy;
    logic [CNT_W-1:0]   r_wr_count;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_winner;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_scan_idx;
    logic [WIDTH-1:0]   w_words [NREQ];
    logic               w_win_req;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_words[i] = Data_In[i*WIDTH +: WIDTH];
        end
    end

    // Scan starts one past the last successful writer and wraps, so the
    // most recent writer is considered last.
    always_comb begin
        w_any      = 1'b0;
        w_pick     = '0;
        w_scan_idx = r_last;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = next_idx(w_scan_idx);
            if (!w_any && Req[w_scan_idx]) begin
                w_any  = 1'b1;
                w_pick = w_scan_idx;
            end
        end
    end

    assign w_win_req = Req[r_winner];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ack      <= '0;
            r_data_out <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_wr_count <= '0;
            r_last     <= LAST_IDX;
            r_winner   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_grant  <= onehot(w_pick);
                        r_winner <= w_pick;
                        r_busy   <= 1'b1;
                        r_state  <= GRANT;
                    end else begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    r_grant <= '0;
                    if (w_win_req) begin
                        r_data_out <= w_words[r_winner];
                        r_owner    <= r_winner;
                        r_last     <= r_winner;
                        r_ack      <= onehot(r_winner);
                        r_wr_count <= r_wr_count + 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        // Winner withdrew: drop the grant without touching history.
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    r_ack   <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Grant    = r_grant;
    assign Ack      = r_ack;
    assign Data_Out = r_data_out;
    assign Owner    = r_owner;
    assign Busy     = r_busy;
    assign Wr_Count = r_wr_count;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter (NREQ=4, WIDTH=32, CNT_W=8) with
// hand-computed expected grants, data, owners and counts.
module tb_rr_reg_write_arbiter;

    logic         Clock;
    logic         Reset;
    logic [3:0]   Req;
    logic [127:0] Data_In;
    logic [3:0]   Grant;
    logic [3:0]   Ack;
    logic [31:0]  Data_Out;
    logic [1:0]   Owner;
    logic         Busy;
    logic [7:0]   Wr_Count;

    int checks;
    int errors;

    rr_reg_write_arbiter #(.NREQ(4), .WIDTH(32), .CNT_W(8)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .Data_In (Data_In),
        .Grant   (Grant),
        .Ack     (Ack),
        .Data_Out(Data_Out),
        .Owner   (Owner),
        .Busy    (Busy),
        .Wr_Count(Wr_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One full transfer to winner w: grant, write+ack, then back to idle.
    task automatic serve(input string tag, input int w, input logic [31:0] dexp,
                         input logic [7:0] cexp, input bit reraise);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        tick();
        chk({tag, " grant"}, 64'(Grant), 64'(oh));
        chk({tag, " busy_g"}, 64'(Busy), 64'd1);
        tick();
        chk({tag, " ack"}, 64'(Ack), 64'(oh));
        chk({tag, " dout"}, 64'(Data_Out), 64'(dexp));
        chk({tag, " owner"}, 64'(Owner), 64'(w));
        chk({tag, " cnt"}, 64'(Wr_Count), 64'(cexp));
        chk({tag, " grant_d"}, 64'(Grant), 64'd0);
        Req[w] = 1'b0;
        tick();
        chk({tag, " ack_off"}, 64'(Ack), 64'd0);
        chk({tag, " no_regrant"}, 64'(Grant), 64'd0);
        if (reraise) Req[w] = 1'b1;
    endtask

    initial begin
        int rr_win [5];
        logic [31:0] rr_dat [5];
        checks  = 0;
        errors  = 0;
        Reset   = 1'b0;
        Req     = 4'b0000;
        Data_In = {32'h44, 32'h33, 32'h22, 32'h11};

        tick();
        tick();
        chk("rst grant", 64'(Grant), 64'd0);
        chk("rst ack", 64'(Ack), 64'd0);
        chk("rst dout", 64'(Data_Out), 64'd0);
        chk("rst owner", 64'(Owner), 64'd0);
        chk("rst busy", 64'(Busy), 64'd0);
        chk("rst cnt", 64'(Wr_Count), 64'd0);
        Reset = 1'b1;

        // Reset asserted mid-GRANT clears outputs without waiting for a clock
        Req = 4'b0001;
        tick();
        chk("t1 grant", 64'(Grant), 64'b0001);
        #2 Reset = 1'b0;
        #1;
        chk("t1 async grant", 64'(Grant), 64'd0);
        chk("t1 async busy", 64'(Busy), 64'd0);
        chk("t1 async ack", 64'(Ack), 64'd0);
        chk("t1 async cnt", 64'(Wr_Count), 64'd0);
        chk("t1 async dout", 64'(Data_Out), 64'd0);
        tick();
        Reset = 1'b1;
        Req   = 4'b1001;
        serve("t1 r0", 0, 32'h11, 8'd1, 1'b0);
        serve("t1 r3", 3, 32'h44, 8'd2, 1'b0);

        // Single requester 2
        Req = 4'b0100;
        serve("t2", 2, 32'h33, 8'd3, 1'b0);
        tick();
        chk("t2 idle grant", 64'(Grant), 64'd0);
        chk("t2 idle busy", 64'(Busy), 64'd0);

        // Round robin, all four requesting, Last=2 so order is 3,0,1,2,3
        rr_win = '{3, 0, 1, 2, 3};
        rr_dat = '{32'h44, 32'h11, 32'h22, 32'h33, 32'h44};
        Req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve("t3 rr", rr_win[i], rr_dat[i], 8'(4 + i), 1'b1);
        end
        Req = 4'b0000;
        tick();

        // Abort by req1; Last stays 3 so the next search starts at 0
        Req = 4'b0010;
        tick();
        chk("t4 grant", 64'(Grant), 64'b0010);
        Req = 4'b0000;
        tick();
        chk("t4 ack", 64'(Ack), 64'd0);
        chk("t4 grant_off", 64'(Grant), 64'd0);
        chk("t4 busy", 64'(Busy), 64'd0);
        chk("t4 dout", 64'(Data_Out), 64'h44);
        chk("t4 cnt", 64'(Wr_Count), 64'd8);
        chk("t4 owner", 64'(Owner), 64'd3);
        Req = 4'b0011;
        serve("t4 r0", 0, 32'h11, 8'd9, 1'b0);
        Req = 4'b0000;
        tick();

        // Contention after a write by req2: 3, then 0, then 1
        Req = 4'b0100;
        serve("t5 r2", 2, 32'h33, 8'd10, 1'b0);
        Req = 4'b1011;
        serve("t5 r3", 3, 32'h44, 8'd11, 1'b0);
        serve("t5 r0", 0, 32'h11, 8'd12, 1'b0);
        serve("t5 r1", 1, 32'h22, 8'd13, 1'b0);

        // Counter wrap over 256 writes from a fresh reset
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            Req = 4'b0010;
            tick();
            tick();
            Req = 4'b0000;
            tick();
            if (i == 254) chk("t6 cnt255", 64'(Wr_Count), 64'd255);
        end
        chk("t6 wrap cnt", 64'(Wr_Count), 64'd0);
        chk("t6 dout", 64'(Data_Out), 64'h22);
        chk("t6 owner", 64'(Owner), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
